rib_arbiter: RTL and testbench
==============================

Name: rib_arbiter

Overview:
- Bus arbiter and address decoder for the RISC-V internal bus (RIB).
- Sits directly downstream of the processor core's data-memory port, which is master 0 (m0).
- A second master, the UART debug/program loader (m1), shares the bus.
- Routes one transfer at a time to one of four slaves, selected by address[31:28], and drives the hold flag the core consumes to stall its pipeline.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 15, maximum wait cycles for a slave ack before an error termination (range 1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_req_i  in  1  core transfer request
- m0_we_i  in  1  core write enable (1 = write, 0 = read)
- m0_addr_i  in  ADDR_W  core address
- m0_wdata_i  in  DATA_W  core write data
- m0_rdata_o  out  DATA_W  read data returned to core
- m0_ack_o  out  1  core transfer complete, 1-cycle pulse
- m1_req_i  in  1  loader request
- m1_we_i  in  1  loader write enable
- m1_addr_i  in  ADDR_W  loader address
- m1_wdata_i  in  DATA_W  loader write data
- m1_rdata_o  out  DATA_W  read data returned to loader
- m1_ack_o  out  1  loader transfer complete, 1-cycle pulse
- s_sel_o  out  4  one-hot slave select
- s_we_o  out  1  slave write enable
- s_addr_o  out  ADDR_W  slave address, bits [31:28] forced to 0
- s_wdata_o  out  DATA_W  slave write data
- s_rdata_i  in  4*DATA_W  slave read data; slave k occupies bits [k*32+31:k*32]
- s_ack_i  in  4  per-slave ack
- rib_hold_flag_o  out  1  stall request to the core
- bus_err_o  out  1  timeout / unmapped-address pulse

Behaviour:
- Reset: asynchronous and active-low; clk is the only clock. While rst_n is low:
  - FSM goes to IDLE; grant = m0; timeout counter = 0.
  - All outputs are 0.
- FSM states:
  - IDLE:
    - If m1_req_i is set, latch grant = m1; otherwise, if m0_req_i is set, latch grant = m0.
    - Go to BUSY on the next edge.
    - Fixed priority: m1 > m0.
  - BUSY:
    - Drive s_sel_o, s_we_o, s_addr_o and s_wdata_o combinationally from the granted master's live inputs.
    - Decode: addr[31:28] = 0..3 gives one-hot slave index; 4..15 is unmapped.
    - Slave outputs are 0 in IDLE.
- Completion, when the selected s_ack_i bit is 1 in BUSY:
  - Pulse the granted master's ack for that same cycle.
  - Its rdata = selected slave's s_rdata_i for that cycle; it is 0 in all other cycles.
  - Next state IDLE, so there is one idle cycle between transfers and the arbiter never performs back-to-back grants.
- Error termination, on an unmapped address or after TIMEOUT BUSY cycles with no ack:
  - Pulse the granted master's ack with rdata = 0, and pulse bus_err_o in the same cycle.
  - Next state IDLE.
  - Unmapped addresses terminate in the first BUSY cycle with no slave select.
- Timeout counter:
  - Increments every BUSY cycle without ack.
  - Clears on entry to IDLE.
  - Saturates; it never wraps.
- Latency: request seen in IDLE at cycle N, slave strobes from N+1, earliest ack at N+1.
- Master rule: a master holds req and its addr/we/wdata stable until its ack. Behaviour on a mid-transfer change is undefined.
- rib_hold_flag_o is combinational:
  - Equals m0_req_i AND NOT m0_ack_o.
  - Additionally asserted whenever grant = m1 and the FSM is in BUSY.
  - Effect: the core stalls while the loader owns the bus, and while its own access is pending.
- Simultaneous m0/m1 requests: m1 wins. m0 is served in the IDLE slot after m1's ack, provided m1 has dropped req.
- An ack on a non-selected slave bit is ignored.
- Reset asserted mid-transfer: the transfer is abandoned, no ack is issued, and the FSM is in IDLE after release.

Test Plan:
1. Core read:
   - Stimulus: m0 read of addr 0x1000_0040 (slave 1); slave 1 acks 2 cycles after select with 0xDEADBEEF.
   - Response: s_sel_o = 0010; s_addr_o = 0x0000_0040; m0_ack_o pulses once with m0_rdata_o = 0xDEADBEEF; rib_hold_flag_o high from req until the ack cycle.
2. Core write:
   - Stimulus: m0 write of 0x1234_5678 to 0x2000_0004; slave 2 acks in the same cycle.
   - Response: s_we_o = 1; s_wdata_o = 0x1234_5678; ack in the cycle after req; then 1 IDLE cycle.
3. Contention:
   - Stimulus: m0 and m1 request in the same cycle.
   - Response: m1 is granted first; rib_hold_flag_o stays high throughout; m0 is granted in the IDLE slot after m1's ack and m1 dropping req.
4. Timeout:
   - Stimulus: m0 reads slave 0, which never acks.
   - Response: after 15 BUSY cycles, m0_ack_o = 1, m0_rdata_o = 0, bus_err_o = 1 for one cycle; FSM returns to IDLE.
5. Unmapped address:
   - Stimulus: m1 accesses 0x8000_0000.
   - Response: s_sel_o = 0000; m1_ack_o and bus_err_o pulse in the first BUSY cycle.
6. Reset mid-transfer:
   - Stimulus: rst_n is pulled low during BUSY with a pending slave.
   - Response: all outputs are 0 immediately (asynchronous); no ack appears; the first request after release is accepted normally.

Source files
------------

// File: rtl/rib_arbiter.sv
// rib_arbiter: two-master (loader over core) RIB arbiter with 4-slave address decode,
// ack timeout and core hold-flag generation.
module rib_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic [DATA_W-1:0]   m0_rdata_o,
    output logic                m0_ack_o,
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                m1_ack_o,
    output logic [3:0]          s_sel_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic [4*DATA_W-1:0] s_rdata_i,
    input  logic [3:0]          s_ack_i,
    output logic                rib_hold_flag_o,
    output logic                bus_err_o
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              grant_q, grant_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              busy, unmapped, ack_sel, err, done;
    logic [1:0]        idx;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;

    always_comb begin
        busy     = state_q == BUSY;
        addr     = grant_q ? m1_addr_i : m0_addr_i;
        idx      = addr[ADDR_W-3:ADDR_W-4];
        unmapped = |addr[ADDR_W-1:ADDR_W-2];
        ack_sel  = busy && !unmapped && s_ack_i[idx];
        // an ack arriving in the last allowed cycle still wins over the timeout
        err      = busy && !ack_sel && (unmapped || cnt_q >= 8'(TIMEOUT - 1));
        done     = ack_sel || err;
        grant_d  = (!busy && m1_req_i) ? 1'b1 : (!busy && m0_req_i) ? 1'b0 : grant_q;
        state_d  = busy ? (done ? IDLE : BUSY) : ((m0_req_i || m1_req_i) ? BUSY : IDLE);
        cnt_d    = (busy && !done) ? cnt_q + {7'd0, cnt_q != 8'hFF} : 8'd0;
        rdata    = ack_sel ? s_rdata_i[32'(idx)*DATA_W +: DATA_W] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        s_sel_o         = (busy && !unmapped) ? (4'b0001 << idx) : 4'b0000;
        s_we_o          = busy && (grant_q ? m1_we_i : m0_we_i);
        s_addr_o        = busy ? {4'b0000, addr[ADDR_W-5:0]} : '0;
        s_wdata_o       = busy ? (grant_q ? m1_wdata_i : m0_wdata_i) : '0;
        m0_ack_o        = done && !grant_q;
        m1_ack_o        = done && grant_q;
        m0_rdata_o      = grant_q ? '0 : rdata;
        m1_rdata_o      = grant_q ? rdata : '0;
        bus_err_o       = err;
        // m0_req_i is a raw input, so the hold flag is gated to stay low in reset
        rib_hold_flag_o = rst_n && ((m0_req_i && !m0_ack_o) || (grant_q && busy));
    end
endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: directed cycle-scripted stimulus for rib_arbiter; ack responses are
// checked by a scoreboard monitor, strobes and hold flag inline.
module tb_rib_arbiter;
    logic         clk, rst_n;
    logic         m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0]  m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic [31:0]  m0_rdata_o, m1_rdata_o, s_addr_o, s_wdata_o;
    logic         m0_ack_o, m1_ack_o, s_we_o, rib_hold_flag_o, bus_err_o;
    logic [3:0]   s_sel_o, s_ack_i;
    logic [127:0] s_rdata_i;

    typedef struct packed {
        logic        m;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    rib_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o),
        .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i),
        .rib_hold_flag_o(rib_hold_flag_o), .bus_err_o(bus_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic m, input logic [31:0] rd, input logic err);
        exp_q.push_back('{m: m, rd: rd, err: err});
    endtask

    // Scoreboard: every ack or bus error must match the next queued response
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m0_ack_o || m1_ack_o || bus_err_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: m0_ack=%b m1_ack=%b err=%b", m0_ack_o, m1_ack_o, bus_err_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_resp", {m1_ack_o, m0_ack_o, m0_rdata_o, m1_rdata_o, bus_err_o},
                        {e.m, !e.m, e.m ? 32'h0 : e.rd, e.m ? e.rd : 32'h0, e.err});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        {m0_req_i, m0_we_i, m1_req_i, m1_we_i} = '0;
        {m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i} = '0;
        s_ack_i   = 4'b0000;
        s_rdata_i = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_1111};
        @(negedge clk);
        chk("reset_outputs", {m0_rdata_o, m0_ack_o, m1_rdata_o, m1_ack_o, s_sel_o, s_we_o,
                              s_addr_o, s_wdata_o, rib_hold_flag_o, bus_err_o}, '0);
        tick();
        rst_n = 1'b1;
        // core read, slave 1 acks on the third BUSY cycle
        m0_req_i = 1'b1; m0_addr_i = 32'h1000_0040;
        push(1'b0, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        chk("rd_idle_sel", s_sel_o, 4'b0000);
        chk("rd_hold_req", rib_hold_flag_o, 1'b1);
        tick();
        @(negedge clk);
        chk("rd_sel", s_sel_o, 4'b0010);
        chk("rd_addr", s_addr_o, 32'h0000_0040);
        chk("rd_hold_busy", {rib_hold_flag_o, m0_ack_o}, 2'b10);
        tick();
        @(negedge clk);
        chk("rd_wait_ack", m0_ack_o, 1'b0);
        tick();
        s_ack_i = 4'b0010;
        @(negedge clk);
        chk("rd_hold_ack", rib_hold_flag_o, 1'b0);
        tick();
        s_ack_i = 4'b0000;
        // core write, slave 2 acks immediately
        m0_we_i = 1'b1; m0_addr_i = 32'h2000_0004; m0_wdata_i = 32'h1234_5678;
        push(1'b0, 32'h2222_2222, 1'b0);
        @(negedge clk);
        chk("wr_idle_sel", s_sel_o, 4'b0000);
        tick();
        s_ack_i = 4'b0100;
        @(negedge clk);
        chk("wr_strobes", {s_sel_o, s_we_o, s_wdata_o, s_addr_o}, {4'b0100, 1'b1, 32'h1234_5678, 32'h0000_0004});
        tick();
        s_ack_i = 4'b0000;
        // timeout: req held through the ack, so this cycle must still be the idle gap
        m0_we_i = 1'b0; m0_addr_i = 32'h0000_0100; m0_wdata_i = '0;
        push(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("gap_idle_sel", s_sel_o, 4'b0000);
        chk("gap_hold", rib_hold_flag_o, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            tick();
            @(negedge clk);
            if (i == 1) chk("to_sel", s_sel_o, 4'b0001);
            chk($sformatf("to_cycle%0d", i), {m0_ack_o, bus_err_o}, {2{i == 15}});
        end
        tick();
        m0_req_i = 1'b0;
        @(negedge clk);
        chk("to_idle", {s_sel_o, m0_ack_o, bus_err_o}, 6'b0);
        // contention: m1 first, stray ack on m0's slave ignored
        m0_req_i = 1'b1; m0_addr_i = 32'h3000_0008;
        m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h1000_0010; m1_wdata_i = 32'hA5A5_A5A5;
        push(1'b1, 32'hDEAD_BEEF, 1'b0);
        push(1'b0, 32'h3333_3333, 1'b0);
        tick();
        s_ack_i = 4'b1000;
        @(negedge clk);
        chk("ct_m1_grant", {s_sel_o, s_we_o, s_wdata_o, s_addr_o}, {4'b0010, 1'b1, 32'hA5A5_A5A5, 32'h0000_0010});
        chk("ct_stray_ack", {m0_ack_o, m1_ack_o, rib_hold_flag_o}, 3'b001);
        tick();
        s_ack_i = 4'b0010;
        @(negedge clk);
        chk("ct_hold_m1_ack", rib_hold_flag_o, 1'b1);
        tick();
        m1_req_i = 1'b0; s_ack_i = 4'b0000;
        @(negedge clk);
        chk("ct_idle_gap", {s_sel_o, rib_hold_flag_o}, 5'b00001);
        tick();
        s_ack_i = 4'b1000;
        @(negedge clk);
        chk("ct_m0_grant", {s_sel_o, s_we_o, s_addr_o, rib_hold_flag_o}, {4'b1000, 1'b0, 32'h0000_0008, 1'b0});
        tick();
        m0_req_i = 1'b0; s_ack_i = 4'b0000;
        // unmapped address from the loader
        m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h8000_0000;
        push(1'b1, 32'h0, 1'b1);
        tick();
        @(negedge clk);
        chk("um_first_busy", {s_sel_o, m1_ack_o, bus_err_o, rib_hold_flag_o}, 7'b0000_111);
        tick();
        m1_req_i = 1'b0;
        // reset during a pending transfer
        m0_req_i = 1'b1; m0_addr_i = 32'h2000_0000;
        tick();
        @(negedge clk);
        chk("rs_busy_sel", s_sel_o, 4'b0100);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_async_zero", {m0_rdata_o, m0_ack_o, m1_rdata_o, m1_ack_o, s_sel_o, s_we_o,
                              s_addr_o, s_wdata_o, rib_hold_flag_o, bus_err_o}, '0);
        s_ack_i = 4'b0100;
        tick();
        tick();
        rst_n = 1'b1; s_ack_i = 4'b0000;
        push(1'b0, 32'h2222_2222, 1'b0);
        @(negedge clk);
        chk("rs_release_idle", {s_sel_o, rib_hold_flag_o}, 5'b00001);
        tick();
        s_ack_i = 4'b0100;
        @(negedge clk);
        chk("rs_regrant", s_sel_o, 4'b0100);
        tick();
        m0_req_i = 1'b0; s_ack_i = 4'b0000;
        tick();
        tick();
        chk("pending_responses", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
